// File: rtl/sync_updown_counter_param.sv
// Parametrised synchronous up/down counter with programmable modulus, clear, clamped load,
// combinational terminal count and registered wrap pulse. Define SYNC_COUNTER_SAT_EN for saturating mode.
module sync_updown_counter_param #(
  parameter int WIDTH     = 4,
  parameter int MODULO    = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] qout,
  output logic             tc,
  output logic             wrap
);

  localparam int             EW      = WIDTH + 1;
  localparam logic [EW-1:0]  MOD_E   = EW'(MODULO);
  localparam logic [EW-1:0]  MAX_E   = EW'(MODULO - 1);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);

  // Extra bit keeps MODULO == 2**WIDTH representable in the comparisons.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [EW-1:0] v_e;
    v_e = {1'b0, v};
    if (v_e >= MOD_E) return MAX_Q;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] q);
    logic [EW-1:0] s_e;
    s_e = {1'b0, q} + EW'(1);
    return s_e[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] q);
    logic [EW-1:0] s_e;
    s_e = {1'b0, q} - EW'(1);
    return s_e[WIDTH-1:0];
  endfunction

  logic             at_top;
  logic             at_bot;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  assign at_top = ({1'b0, qout} == MAX_E);
  assign at_bot = (qout == '0);
  assign tc     = en & ~clr & ~load & (up_dn ? at_top : at_bot);

  always_comb begin
    q_nxt    = qout;
    wrap_nxt = 1'b0;
    if (clr) begin
      q_nxt = '0;
    end else if (load) begin
      q_nxt = clamp_load(load_val);
    end else if (en) begin
      if (up_dn) begin
        if (at_top) begin
`ifdef SYNC_COUNTER_SAT_EN
          q_nxt = qout;
`else
          q_nxt    = '0;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = step_up(qout);
        end
      end else begin
        if (at_bot) begin
`ifdef SYNC_COUNTER_SAT_EN
          q_nxt = qout;
`else
          q_nxt    = MAX_Q;
          wrap_nxt = 1'b1;
`endif
        end else begin
          q_nxt = step_down(qout);
        end
      end
    end
  end

  // Count register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qout <= RESET_Q;
      wrap <= 1'b0;
    end else begin
      qout <= q_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_sync_updown_counter_param.sv
// Directed bench for sync_updown_counter_param: a WIDTH=4/MODULO=10 instance and a
// WIDTH=2/MODULO=4 full-range instance.
module tb_sync_updown_counter_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up_dn, clr, load;
  logic [3:0] load_val;
  logic [3:0] qout;
  logic       tc, wrap;

  logic       en2, up_dn2, clr2, load2;
  logic [1:0] load_val2;
  logic [1:0] qout2;
  logic       tc2, wrap2;

  int vectors = 0;
  int miscompares = 0;

  sync_updown_counter_param #(.WIDTH(4), .MODULO(10), .RESET_VAL(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .qout(qout), .tc(tc), .wrap(wrap)
  );

  sync_updown_counter_param #(.WIDTH(2), .MODULO(4), .RESET_VAL(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .up_dn(up_dn2), .clr(clr2), .load(load2),
    .load_val(load_val2), .qout(qout2), .tc(tc2), .wrap(wrap2)
  );

  always #5 clk = ~clk;

  // Out-of-range count values must never appear
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      vectors++;
      if (qout >= 4'd10) begin
        miscompares++;
        $display("FAIL range: qout=%0d required < 10", qout);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 0; up_dn = 1; clr = 0; load = 0; load_val = 0;
    en2 = 0; up_dn2 = 1; clr2 = 0; load2 = 0; load_val2 = 0;
    #2;
    vectors++;
    if (qout !== 4'd0 || wrap !== 1'b0 || tc !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_init: qout=%0d wrap=%b tc=%b required 0 0 0", qout, wrap, tc);
    end
    @(negedge clk) rst_n = 1'b1;
    en = 1;
    repeat (5) tick();
    vectors++;
    if (qout !== 4'd5) begin
      miscompares++;
      $display("FAIL reset_precount: qout=%0d required 5", qout);
    end
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (qout !== 4'd0 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: qout=%0d wrap=%b required 0 0", qout, wrap);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (qout !== 4'd0) begin
        miscompares++;
        $display("FAIL reset_hold[%0d]: qout=%0d required 0", i, qout);
      end
    end
    en = 0;
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_up_wrap();
    logic [3:0] exp_q [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic [3:0] prev;
    clr = 1; tick(); clr = 0;
    en = 1; up_dn = 1;
    prev = 4'd0;
    for (int i = 0; i < 12; i++) begin
      #1;
      vectors++;
      if (tc !== (prev == 4'd9)) begin
        miscompares++;
        $display("FAIL up_tc[%0d]: tc=%b required %b", i, tc, (prev == 4'd9));
      end
      tick();
      vectors++;
      if (qout !== exp_q[i] || wrap !== (i == 9)) begin
        miscompares++;
        $display("FAIL up_q[%0d]: qout=%0d wrap=%b required %0d %b", i, qout, wrap, exp_q[i], (i == 9));
      end
      prev = exp_q[i];
    end
    en = 0;
  endtask

  task automatic test_down_wrap();
    logic [3:0] exp_q [3] = '{4'd0, 4'd9, 4'd8};
    logic [3:0] prev;
    load = 1; load_val = 4'd1; tick(); load = 0;
    vectors++;
    if (qout !== 4'd1 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL down_load: qout=%0d wrap=%b required 1 0", qout, wrap);
    end
    en = 1; up_dn = 0;
    prev = 4'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (tc !== (prev == 4'd0)) begin
        miscompares++;
        $display("FAIL down_tc[%0d]: tc=%b required %b", i, tc, (prev == 4'd0));
      end
      tick();
      vectors++;
      if (qout !== exp_q[i] || wrap !== (i == 1)) begin
        miscompares++;
        $display("FAIL down_q[%0d]: qout=%0d wrap=%b required %0d %b", i, qout, wrap, exp_q[i], (i == 1));
      end
      prev = exp_q[i];
    end
    en = 0;
  endtask

  task automatic test_priority();
    load = 1; load_val = 4'd7; tick();
    clr = 1; load = 1; en = 1; up_dn = 1; load_val = 4'd3;
    #1;
    vectors++;
    if (tc !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_tc: tc=%b required 0", tc);
    end
    tick();
    vectors++;
    if (qout !== 4'd0 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_clr: qout=%0d wrap=%b required 0 0", qout, wrap);
    end
    clr = 0; load = 1; load_val = 4'd12;
    tick();
    vectors++;
    if (qout !== 4'd9 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_clamp: qout=%0d wrap=%b required 9 0", qout, wrap);
    end
    load = 0; en = 0;
  endtask

  task automatic test_hold_flip();
    logic [3:0] exp_q [4] = '{4'd4, 4'd3, 4'd4, 4'd3};
    load = 1; load_val = 4'd3; tick(); load = 0;
    en = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (qout !== 4'd3 || tc !== 1'b0) begin
        miscompares++;
        $display("FAIL hold[%0d]: qout=%0d tc=%b required 3 0", i, qout, tc);
      end
    end
    en = 1;
    for (int i = 0; i < 4; i++) begin
      up_dn = (i % 2 == 0);
      tick();
      vectors++;
      if (qout !== exp_q[i]) begin
        miscompares++;
        $display("FAIL flip[%0d]: qout=%0d required %0d", i, qout, exp_q[i]);
      end
    end
    en = 0;
  endtask

  task automatic test_saturate();
    load = 1; load_val = 4'd8; tick(); load = 0;
    en = 1; up_dn = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (qout !== 4'd9 || wrap !== 1'b0 || tc !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_up[%0d]: qout=%0d wrap=%b tc=%b required 9 0 1", i, qout, wrap, tc);
      end
    end
    en = 0; load = 1; load_val = 4'd1; tick(); load = 0;
    en = 1; up_dn = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (qout !== 4'd0 || wrap !== 1'b0 || tc !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_down[%0d]: qout=%0d wrap=%b tc=%b required 0 0 1", i, qout, wrap, tc);
      end
    end
    en = 0;
  endtask

  task automatic test_full_range();
    logic [1:0] exp_q [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    clr2 = 1; tick(); clr2 = 0;
    vectors++;
    if (qout2 !== 2'd0) begin
      miscompares++;
      $display("FAIL full_clr: qout=%0d required 0", qout2);
    end
    en2 = 1; up_dn2 = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (tc2 !== (i == 3)) begin
        miscompares++;
        $display("FAIL full_tc[%0d]: tc=%b required %b", i, tc2, (i == 3));
      end
      tick();
      vectors++;
      if (qout2 !== exp_q[i] || wrap2 !== (i == 3)) begin
        miscompares++;
        $display("FAIL full_q[%0d]: qout=%0d wrap=%b required %0d %b", i, qout2, wrap2, exp_q[i], (i == 3));
      end
    end
    en2 = 0;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_hold_flip();
`ifdef SYNC_COUNTER_SAT_EN
    test_saturate();
`else
    test_up_wrap();
    test_down_wrap();
    test_full_range();
`endif
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
